// File: rtl/sub_seq_pkg.sv
// Shared types and defaults for the nibble-serial subtractor controller.
package sub_seq_pkg;

  localparam int unsigned NibblesDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/subtractor_4bit.sv
// 4-bit subtractor with borrow: {B_out, d} = a - b - C_in.
module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       C_in,
  output logic [3:0] d,
  output logic       B_out
);

  logic [4:0] res;

  // Bit 4 of the zero-extended difference goes high exactly when a < b + C_in.
  assign res = {1'b0, a} - {1'b0, b} - {4'b0000, C_in};
  assign d = res[3:0];
  assign B_out = res[4];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Sequential W-bit subtractor: one nibble per cycle through a shared 4-bit
// subtractor, LSB first, with a one-cycle done pulse carrying the result.
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = NibblesDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    shadow_q;
  logic [W-1:0]    shadow_nxt;
  logic            bin_q;
  logic            borrow_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW+1:0] base;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_d;
  logic            nib_bin;
  logic            nib_bout;

  always_comb begin
    base = {idx_q, 2'b00};
    nib_a = a_q[base +: 4];
    nib_b = b_q[base +: 4];
    // Nibble 0 takes the captured borrow-in; later nibbles chain the registered borrow.
    nib_bin = (idx_q == '0) ? bin_q : borrow_q;
    shadow_nxt = shadow_q;
    shadow_nxt[base +: 4] = nib_d;
  end

  subtractor_4bit u_sub (
    .a    (nib_a),
    .b    (nib_b),
    .C_in (nib_bin),
    .d    (nib_d),
    .B_out(nib_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            bin_q    <= bin;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          shadow_q <= shadow_nxt;
          borrow_q <= nib_bout;
          if (idx_q == LastIdx) begin
            // Result leaves on DONE entry, so merge the final nibble directly.
            diff    <= shadow_nxt;
            bout    <= nib_bout;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl at the default width of four nibbles.
module tb_sub_seq_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the last run_op call.
  int           op_lat;
  int           op_pulses;
  logic [W-1:0] op_diff;
  logic         op_bout;
  int           op_diff_changes;

  sub_seq_ctrl #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a_in (a_in),
    .b_in (b_in),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 1 is the first cycle after the accepting edge; done is expected in cycle 5.
  // With glitch set, start is re-pulsed in RUN with different operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit glitch);
    logic [W-1:0] prev_diff;
    @(negedge clk);
    a_in = a;
    b_in = b;
    bin = bi;
    start = 1'b1;
    prev_diff = diff;
    op_lat = 0;
    op_pulses = 0;
    op_diff = 'x;
    op_bout = 1'bx;
    op_diff_changes = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start = 1'b0;
        a_in = ~a;
        b_in = ~b;
        bin = ~bi;
      end
      if (glitch && i == 2) begin
        start = 1'b1;
        a_in = 16'hAAAA;
        b_in = 16'h1111;
        bin = 1'b1;
      end
      if (glitch && i == 3) start = 1'b0;
      if (done) begin
        op_pulses++;
        if (op_lat == 0) begin
          op_lat = i;
          op_diff = diff;
          op_bout = bout;
        end
      end else if (op_lat == 0 && diff !== prev_diff) begin
        op_diff_changes++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a_in = 16'h5555;
    b_in = 16'h1111;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    n_tests++;
    if (diff !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_diff: got %h expected 0000", diff);
    end
    n_tests++;
    if (bout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bout: got %b expected 0", bout);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_latency();
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0);
    n_tests++;
    if (op_lat !== 5) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d expected 5", op_lat);
    end
    n_tests++;
    if (op_pulses !== 1) begin
      n_fail++;
      $display("FAIL zero_pulses: got %0d expected 1", op_pulses);
    end
    n_tests++;
    if (op_diff !== 16'h0000 || op_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_result: got %h/%b expected 0000/0", op_diff, op_bout);
    end
  endtask

  task automatic test_ripple();
    run_op(16'h1234, 16'h0235, 1'b0, 1'b0);
    n_tests++;
    if (op_diff !== 16'h0FFF || op_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_result: got %h/%b expected 0fff/0", op_diff, op_bout);
    end
    n_tests++;
    if (op_lat !== 5) begin
      n_fail++;
      $display("FAIL ripple_latency: got %0d expected 5", op_lat);
    end
    n_tests++;
    if (op_diff_changes !== 0) begin
      n_fail++;
      $display("FAIL ripple_diff_stable: got %0d changes expected 0", op_diff_changes);
    end
    n_tests++;
    if (busy !== 1'b0 || diff !== 16'h0FFF) begin
      n_fail++;
      $display("FAIL ripple_hold: got busy=%b diff=%h expected 0/0fff", busy, diff);
    end
  endtask

  task automatic test_borrow_in();
    run_op(16'h0001, 16'h0002, 1'b1, 1'b0);
    n_tests++;
    if (op_diff !== 16'hFFFE || op_bout !== 1'b1) begin
      n_fail++;
      $display("FAIL bin_small: got %h/%b expected fffe/1", op_diff, op_bout);
    end
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    n_tests++;
    if (op_diff !== 16'hFFFF || op_bout !== 1'b1) begin
      n_fail++;
      $display("FAIL bin_full: got %h/%b expected ffff/1", op_diff, op_bout);
    end
  endtask

  task automatic test_start_during_run();
    run_op(16'h1234, 16'h0235, 1'b0, 1'b1);
    n_tests++;
    if (op_diff !== 16'h0FFF || op_bout !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_result: got %h/%b expected 0fff/0", op_diff, op_bout);
    end
    n_tests++;
    if (op_pulses !== 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 1", op_pulses);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    run_op(16'h0001, 16'h0002, 1'b1, 1'b0);
    @(negedge clk);
    a_in = 16'h8000;
    b_in = 16'h0001;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0/0", busy, done);
    end
    n_tests++;
    if (diff !== 16'h0000 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_data: got %h/%b expected 0000/0", diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses);
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    n_tests++;
    if (op_diff !== 16'h7FFF || op_bout !== 1'b0 || op_lat !== 5) begin
      n_fail++;
      $display("FAIL midrst_resume: got %h/%b lat %0d expected 7fff/0 lat 5",
               op_diff, op_bout, op_lat);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int cnt;
    int bad_diff;
    cnt = 0;
    bad_diff = 0;
    @(negedge clk);
    a_in = 16'h00FF;
    b_in = 16'h0001;
    bin = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (cnt < 3) t[cnt] = i;
        cnt++;
        if (diff !== 16'h00FE || bout !== 1'b0) bad_diff++;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (cnt !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 3", cnt);
    end
    n_tests++;
    if (bad_diff !== 0) begin
      n_fail++;
      $display("FAIL b2b_result: got %0d wrong results expected 0", bad_diff);
    end
    if (cnt >= 3) begin
      n_tests++;
      if (t[0] !== 5) begin
        n_fail++;
        $display("FAIL b2b_first: got cycle %0d expected 5", t[0]);
      end
      n_tests++;
      if (t[1] - t[0] !== 6 || t[2] - t[1] !== 6) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d,%0d expected 6,6", t[1] - t[0], t[2] - t[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    bin = 1'b0;
    test_reset();
    test_zero_latency();
    test_ripple();
    test_borrow_in();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
